alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one combinational ALU between two requesters, port 0 (UART front-end) and port 1 (local switch/button front-end).
- Arbitrates incoming operation requests round-robin and latches the winning request's operands/opcode onto the ALU inputs.
- Waits a fixed settling latency, captures the result, and returns it to the winning requester over a valid/ready response channel.
- Sits between the requester front-ends and the ALU instance.

Parameters:
DATA_WIDTH, 8, operand and result width in bits
OPCODE_SZ, 6, ALU opcode width in bits
ALU_LAT, 1, cycles the ALU inputs are held before the result is sampled (legal range 1..15)

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_req0_valid  input  1  port 0 request valid
i_req0_op_a  input  DATA_WIDTH  port 0 operand A
i_req0_op_b  input  DATA_WIDTH  port 0 operand B
i_req0_opcode  input  OPCODE_SZ  port 0 opcode
o_req0_ready  output  1  port 0 request accepted this cycle
o_rsp0_valid  output  1  port 0 result valid
o_rsp0_data  output  DATA_WIDTH  port 0 result
i_rsp0_ready  input  1  port 0 result consumed
i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_opcode, o_req1_ready, o_rsp1_valid, o_rsp1_data, i_rsp1_ready: same directions, widths and meaning for port 1
o_alu_op_a  output  DATA_WIDTH  ALU operand A
o_alu_op_b  output  DATA_WIDTH  ALU operand B
o_alu_opcode  output  OPCODE_SZ  ALU opcode
i_alu_result  input  DATA_WIDTH  ALU result, combinational from o_alu_*
o_busy  output  1  high whenever state is not IDLE
o_grant  output  1  index of the port owning the current or last transaction

Behaviour:
- Reset (async, active-high): state IDLE; all o_alu_*, o_rsp*_data and result register = 0; o_rsp*_valid = 0; o_busy = 0; o_grant = 0; wait counter = 0; last_grant = 1, so port 0 wins the first tie.
- States: IDLE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration (combinational):
  - Only one port valid: that port wins.
  - Both ports valid: the port != last_grant wins.
  - Neither valid: stay in IDLE.
- IDLE, acceptance:
  - o_reqN_ready = (state == IDLE) && winner == N; combinational, single-cycle.
  - Transfer occurs on the cycle valid && ready.
  - At that clock edge: latch op_a/op_b/opcode into the o_alu_* registers; set o_grant = last_grant = N; load counter = ALU_LAT-1; go to WAIT.
  - The loser's ready stays 0. The loser may hold or drop valid; no state is kept for it.
- WAIT:
  - o_alu_* stay stable.
  - Counter decrements each cycle.
  - On the cycle the counter = 0: capture i_alu_result into the result register at the edge; go to RESP.
- RESP:
  - o_rsp{o_grant}_valid = 1 and o_rsp{o_grant}_data = result. The other port's valid = 0.
  - Data holds steady while valid && !ready.
  - When i_rsp{o_grant}_ready = 1 (including in the first RESP cycle): valid drops at the next edge and state goes to IDLE.
  - No request is accepted during RESP.
- Latency: accept in cycle T -> rsp valid first asserted in cycle T+ALU_LAT+1. Minimum issue interval is ALU_LAT+2 cycles (one IDLE bubble after each response).
- o_rspN_data for the non-granted port holds its last value (don't care); benches check data only when valid.
- o_alu_* keep the last transaction's values in IDLE; they are never cleared except by reset.
- Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1...
- A request whose valid drops before acceptance is silently ignored.
- Reset mid-WAIT or mid-RESP: the transaction is discarded, no response is issued, and the block returns to the reset state immediately (asynchronously).
- Request inputs are sampled only in the acceptance cycle; changes at any other time have no effect.
- Illegal state encoding -> IDLE.

Test Plan:
- Single request: reset, req0 op_a=0x12, op_b=0x34, opcode=0x20 (ALU model = add), ALU_LAT=1, rsp0_ready=1 -> ready0 high in cycle T; o_alu_op_a=0x12 from T+1; rsp0_valid high in T+2 with data 0x46; ready1 and rsp1_valid never high.
- Tie and fairness: req0 and req1 both continuously valid, 4 transactions -> grant order 0,1,0,1; each rsp arrives on the matching port with the correct result; o_grant matches.
- Backpressure: req1 op_a=0xF0, op_b=0x0F, opcode OR; hold rsp1_ready=0 for 5 cycles -> rsp1_valid held with data 0xFF; req0 asserted meanwhile is not accepted; req0 is accepted in the cycle after the rsp1 handshake + IDLE.
- Latency parameter: ALU_LAT=3, single req0 -> o_alu_* stable for 3 cycles; rsp0_valid first high at T+4; ALU model changes its output only after 2 cycles, and the captured value is still correct.
- Reset mid-operation: assert i_reset during WAIT -> o_busy=0, rsp valids=0, o_alu_*=0 immediately; after release, a subsequent tie grants port 0 first.
- Withdrawn request: req1 valid for 1 cycle while a transaction is in WAIT, then dropped -> no port-1 transaction occurs; block returns to IDLE with ready1 never high.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if
//   Bundles the request, response and ALU-side signals of alu_req_arbiter.
//   The signal names are the block's port names.
//   slave  : arbiter side (drives o_*, reads i_*)
//   master : environment side (drives i_*, reads o_*)
//   Per requester N (0/1):
//     i_reqN_valid, i_reqN_op_a, i_reqN_op_b, i_reqN_opcode, o_reqN_ready
//     o_rspN_valid, o_rspN_data, i_rspN_ready
//   ALU side:
//     o_alu_op_a, o_alu_op_b, o_alu_opcode, i_alu_result
interface alu_req_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OPCODE_SZ  = 6
);
  logic                  i_req0_valid;
  logic [DATA_WIDTH-1:0] i_req0_op_a;
  logic [DATA_WIDTH-1:0] i_req0_op_b;
  logic [OPCODE_SZ-1:0]  i_req0_opcode;
  logic                  o_req0_ready;
  logic                  o_rsp0_valid;
  logic [DATA_WIDTH-1:0] o_rsp0_data;
  logic                  i_rsp0_ready;

  logic                  i_req1_valid;
  logic [DATA_WIDTH-1:0] i_req1_op_a;
  logic [DATA_WIDTH-1:0] i_req1_op_b;
  logic [OPCODE_SZ-1:0]  i_req1_opcode;
  logic                  o_req1_ready;
  logic                  o_rsp1_valid;
  logic [DATA_WIDTH-1:0] o_rsp1_data;
  logic                  i_rsp1_ready;

  logic [DATA_WIDTH-1:0] o_alu_op_a;
  logic [DATA_WIDTH-1:0] o_alu_op_b;
  logic [OPCODE_SZ-1:0]  o_alu_opcode;
  logic [DATA_WIDTH-1:0] i_alu_result;

  modport slave (
    input  i_req0_valid, i_req0_op_a, i_req0_op_b, i_req0_opcode, i_rsp0_ready,
    input  i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_opcode, i_rsp1_ready,
    input  i_alu_result,
    output o_req0_ready, o_rsp0_valid, o_rsp0_data,
    output o_req1_ready, o_rsp1_valid, o_rsp1_data,
    output o_alu_op_a, o_alu_op_b, o_alu_opcode
  );

  modport master (
    output i_req0_valid, i_req0_op_a, i_req0_op_b, i_req0_opcode, i_rsp0_ready,
    output i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_opcode, i_rsp1_ready,
    output i_alu_result,
    input  o_req0_ready, o_rsp0_valid, o_rsp0_data,
    input  o_req1_ready, o_rsp1_valid, o_rsp1_data,
    input  o_alu_op_a, o_alu_op_b, o_alu_opcode
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one combinational ALU between two requesters (port 0: UART
//   front-end, port 1: switch/button front-end). Requests are arbitrated
//   round-robin, the winner's operands are latched onto the ALU inputs,
//   held for ALU_LAT cycles, and the sampled result is returned to the
//   winner over a valid/ready response channel.
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous, active-high reset
//   bus      : request/response channels of both ports and the ALU side
//   o_busy   : high whenever the block is not idle
//   o_grant  : port owning the current or most recent transaction
// Parameters:
//   DATA_WIDTH : operand/result width
//   OPCODE_SZ  : opcode width
//   ALU_LAT    : cycles the ALU inputs are held before sampling (1..15)
module alu_req_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int OPCODE_SZ  = 6,
  parameter int ALU_LAT    = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  alu_req_arbiter_if.slave  bus,
  output logic              o_busy,
  output logic              o_grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Counter runs ALU_LAT-1 down to 0, so ALU_LAT=1 spends one cycle in WAIT.
  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPCODE_SZ-1:0]  alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic any_valid;
  logic winner;
  logic accept;
  logic rsp_ready_sel;

  // Round-robin: on a tie the port that did not win last time goes first;
  // otherwise the only valid port wins.
  assign any_valid     = bus.i_req0_valid | bus.i_req1_valid;
  assign winner        = (bus.i_req0_valid & bus.i_req1_valid) ? ~last_grant_q
                                                               : bus.i_req1_valid;
  assign accept        = (state_q == ST_IDLE) & any_valid;
  assign rsp_ready_sel = grant_q ? bus.i_rsp1_ready : bus.i_rsp0_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    result_d     = result_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_a_d      = winner ? bus.i_req1_op_a   : bus.i_req0_op_a;
          alu_b_d      = winner ? bus.i_req1_op_b   : bus.i_req0_op_b;
          alu_op_d     = winner ? bus.i_req1_opcode : bus.i_req0_opcode;
          grant_d      = winner;
          last_grant_d = winner;
          cnt_d        = CNT_LOAD;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          result_d = bus.i_alu_result;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_sel) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_req0_ready = accept & ~winner;
  assign bus.o_req1_ready = accept &  winner;

  // Both data outputs carry the result register; only the granted port's
  // valid is raised, so the other port simply sees a stale value.
  assign bus.o_rsp0_valid = (state_q == ST_RESP) & ~grant_q;
  assign bus.o_rsp1_valid = (state_q == ST_RESP) &  grant_q;
  assign bus.o_rsp0_data  = result_q;
  assign bus.o_rsp1_data  = result_q;

  assign bus.o_alu_op_a   = alu_a_q;
  assign bus.o_alu_op_b   = alu_b_q;
  assign bus.o_alu_opcode = alu_op_q;

  assign o_busy  = (state_q != ST_IDLE);
  assign o_grant = grant_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter. dut_a (ALU_LAT=1) is driven by
// directed and random traffic and checked against a transaction-level model;
// dut_b (ALU_LAT=3) sits behind an ALU whose output lags its inputs by two
// cycles and is checked with a short directed sequence.
module tb_alu_req_arbiter;
  localparam int DW    = 8;
  localparam int OS    = 6;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_req_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_SZ(OS)) bus_a ();
  alu_req_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_SZ(OS)) bus_b ();
  logic busy_a, grant_a, busy_b, grant_b;

  alu_req_arbiter #(.DATA_WIDTH(DW), .OPCODE_SZ(OS), .ALU_LAT(LAT_A)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(bus_a), .o_busy(busy_a), .o_grant(grant_a));
  alu_req_arbiter #(.DATA_WIDTH(DW), .OPCODE_SZ(OS), .ALU_LAT(LAT_B)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(bus_b), .o_busy(busy_b), .o_grant(grant_b));

  // Small ALU: MIPS-style function codes.
  function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a;
    endcase
  endfunction

  assign bus_a.i_alu_result = alu_fn(bus_a.o_alu_opcode, bus_a.o_alu_op_a, bus_a.o_alu_op_b);

  // dut_b's ALU presents a result only two cycles after its inputs change.
  logic [7:0] da1 = '0, da2 = '0, db1 = '0, db2 = '0;
  logic [5:0] dop1 = '0, dop2 = '0;
  always @(posedge clk) begin
    da1 <= bus_b.o_alu_op_a;   da2 <= da1;
    db1 <= bus_b.o_alu_op_b;   db2 <= db1;
    dop1 <= bus_b.o_alu_opcode; dop2 <= dop1;
  end
  assign bus_b.i_alu_result = alu_fn(dop2, da2, db2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int         port;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];

  bit         m_busy = 1'b0;
  int         m_port = 0;
  bit         m_last = 1'b1;
  bit         m_grant = 1'b0;
  int         m_rsp_cyc = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [5:0] m_op = '0;

  // The block is either free (accepts any valid request) or owns one
  // transaction whose response is due LAT+1 cycles after acceptance and
  // is held until the requester is ready.
  always @(negedge clk) begin : model
    bit v0, v1, take, rdy;
    int win;
    if (rst) begin
      m_busy = 1'b0; m_last = 1'b1; m_grant = 1'b0;
      m_a = '0; m_b = '0; m_op = '0;
      sb_q.delete();
    end else begin
      v0   = bus_a.i_req0_valid;
      v1   = bus_a.i_req1_valid;
      take = !m_busy && (v0 || v1);
      win  = (v0 && v1) ? (m_last ? 0 : 1) : (v1 ? 1 : 0);
      chk("req0_ready", 32'(bus_a.o_req0_ready), 32'(take && win == 0));
      chk("req1_ready", 32'(bus_a.o_req1_ready), 32'(take && win == 1));
      chk("busy", 32'(busy_a), 32'(m_busy));
      chk("grant", 32'(grant_a), 32'(m_grant));
      chk("rsp0_valid", 32'(bus_a.o_rsp0_valid), 32'(m_busy && cyc >= m_rsp_cyc && m_port == 0));
      chk("rsp1_valid", 32'(bus_a.o_rsp1_valid), 32'(m_busy && cyc >= m_rsp_cyc && m_port == 1));
      chk("alu_op_a", 32'(bus_a.o_alu_op_a), 32'(m_a));
      chk("alu_op_b", 32'(bus_a.o_alu_op_b), 32'(m_b));
      chk("alu_opcode", 32'(bus_a.o_alu_opcode), 32'(m_op));
      rdy = (m_port == 0) ? bus_a.i_rsp0_ready : bus_a.i_rsp1_ready;
      if (take) begin
        m_a  = win ? bus_a.i_req1_op_a   : bus_a.i_req0_op_a;
        m_b  = win ? bus_a.i_req1_op_b   : bus_a.i_req0_op_b;
        m_op = win ? bus_a.i_req1_opcode : bus_a.i_req0_opcode;
        m_busy = 1'b1; m_port = win; m_last = (win == 1); m_grant = (win == 1);
        m_rsp_cyc = cyc + LAT_A + 1;
        sb_q.push_back('{win, alu_fn(m_op, m_a, m_b), m_rsp_cyc});
      end else if (m_busy && cyc >= m_rsp_cyc && rdy) begin
        m_busy = 1'b0;
      end
    end
  end

  bit seen = 1'b0;
  always @(negedge clk) begin : monitor
    if (rst) begin
      seen = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        bit v, r;
        logic [7:0] d;
        v = (p == 0) ? bus_a.o_rsp0_valid : bus_a.o_rsp1_valid;
        r = (p == 0) ? bus_a.i_rsp0_ready : bus_a.i_rsp1_ready;
        d = (p == 0) ? bus_a.o_rsp0_data  : bus_a.o_rsp1_data;
        if (v) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected at cycle %0d: port %0d valid with data 0x%0h, expected no response", cyc, p, d);
          end else begin
            chk("rsp_port", 32'(p), 32'(sb_q[0].port));
            chk("rsp_data", 32'(d), 32'(sb_q[0].data));
            if (!seen) begin
              chk("rsp_latency", 32'(cyc), 32'(sb_q[0].cyc));
              seen = 1'b1;
            end
            if (r) begin
              grant_log.push_back(p);
              void'(sb_q.pop_front());
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] ops_tbl [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h3F};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int p, input bit v, input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] op);
    if (p == 0) begin
      bus_a.i_req0_valid = v; bus_a.i_req0_op_a = a; bus_a.i_req0_op_b = b; bus_a.i_req0_opcode = op;
    end else begin
      bus_a.i_req1_valid = v; bus_a.i_req1_op_a = a; bus_a.i_req1_op_b = b; bus_a.i_req1_opcode = op;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy_a || sb_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 60), 32'(1));
  endtask

  initial begin
    int exp_ord[4] = '{0, 1, 0, 1};

    set_req(0, 1'b0, 8'h00, 8'h00, 6'h00);
    set_req(1, 1'b0, 8'h00, 8'h00, 6'h00);
    bus_a.i_rsp0_ready = 1'b1; bus_a.i_rsp1_ready = 1'b1;
    bus_b.i_req0_valid = 1'b0; bus_b.i_req0_op_a = '0; bus_b.i_req0_op_b = '0; bus_b.i_req0_opcode = '0;
    bus_b.i_req1_valid = 1'b0; bus_b.i_req1_op_a = '0; bus_b.i_req1_op_b = '0; bus_b.i_req1_opcode = '0;
    bus_b.i_rsp0_ready = 1'b1; bus_b.i_rsp1_ready = 1'b1;

    // Reset state.
    repeat (3) tick();
    chk("rst_alu_op_a", 32'(bus_a.o_alu_op_a), 32'(0));
    chk("rst_alu_op_b", 32'(bus_a.o_alu_op_b), 32'(0));
    chk("rst_alu_opcode", 32'(bus_a.o_alu_opcode), 32'(0));
    chk("rst_rsp0_data", 32'(bus_a.o_rsp0_data), 32'(0));
    chk("rst_rsp1_data", 32'(bus_a.o_rsp1_data), 32'(0));
    chk("rst_rsp_valid", 32'({bus_a.o_rsp0_valid, bus_a.o_rsp1_valid}), 32'(0));
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_grant", 32'(grant_a), 32'(0));
    rst = 1'b0;
    tick();

    // Tie with both ports continuously valid: grants alternate, port 0 first.
    grant_log.delete();
    for (int i = 0; i < 10; i++) begin
      set_req(0, 1'b1, 8'($urandom), 8'($urandom), ops_tbl[$urandom_range(0, 6)]);
      set_req(1, 1'b1, 8'($urandom), 8'($urandom), ops_tbl[$urandom_range(0, 6)]);
      tick();
    end
    set_req(0, 1'b0, 8'h00, 8'h00, 6'h00);
    set_req(1, 1'b0, 8'h00, 8'h00, 6'h00);
    wait_idle("tie_drain");
    chk("tie_count", 32'(grant_log.size()), 32'(4));
    if (grant_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("tie_order", 32'(grant_log[i]), 32'(exp_ord[i]));

    // Single request on port 0: 0x12 + 0x34.
    set_req(0, 1'b1, 8'h12, 8'h34, 6'h20);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00, 6'h00);
    wait_idle("single_drain");
    chk("single_alu_held", 32'(bus_a.o_alu_op_a), 32'(8'h12));
    chk("single_result", 32'(bus_a.o_rsp0_data), 32'(8'h46));

    // Backpressure on port 1 while port 0 waits.
    bus_a.i_rsp1_ready = 1'b0;
    set_req(1, 1'b1, 8'hF0, 8'h0F, 6'h25);
    tick();
    set_req(1, 1'b0, 8'h00, 8'h00, 6'h00);
    set_req(0, 1'b1, 8'h11, 8'h22, 6'h20);
    repeat (5) tick();
    chk("bp_rsp1_valid", 32'(bus_a.o_rsp1_valid), 32'(1));
    chk("bp_rsp1_data", 32'(bus_a.o_rsp1_data), 32'(8'hFF));
    chk("bp_req0_blocked", 32'(bus_a.o_req0_ready), 32'(0));
    bus_a.i_rsp1_ready = 1'b1;
    tick();
    chk("bp_req0_accept", 32'(bus_a.o_req0_ready), 32'(1));
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00, 6'h00);
    wait_idle("bp_drain");

    // Port 1 request withdrawn while port 0 is being served.
    grant_log.delete();
    set_req(0, 1'b1, 8'h05, 8'h03, 6'h22);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00, 6'h00);
    set_req(1, 1'b1, 8'hAA, 8'h55, 6'h26);
    tick();
    set_req(1, 1'b0, 8'h00, 8'h00, 6'h00);
    wait_idle("withdraw_drain");
    chk("withdraw_count", 32'(grant_log.size()), 32'(1));

    // Random traffic with random response backpressure.
    for (int i = 0; i < 600; i++) begin
      set_req(0, $urandom_range(0, 99) < 40, 8'($urandom), 8'($urandom), ops_tbl[$urandom_range(0, 6)]);
      set_req(1, $urandom_range(0, 99) < 40, 8'($urandom), 8'($urandom), ops_tbl[$urandom_range(0, 6)]);
      bus_a.i_rsp0_ready = ($urandom_range(0, 99) < 70);
      bus_a.i_rsp1_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    set_req(0, 1'b0, 8'h00, 8'h00, 6'h00);
    set_req(1, 1'b0, 8'h00, 8'h00, 6'h00);
    bus_a.i_rsp0_ready = 1'b1; bus_a.i_rsp1_ready = 1'b1;
    wait_idle("random_drain");

    // Reset asserted mid-WAIT takes effect without a clock edge.
    set_req(0, 1'b1, 8'h77, 8'h11, 6'h20);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00, 6'h00);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_a), 32'(0));
    chk("arst_rsp_valid", 32'({bus_a.o_rsp0_valid, bus_a.o_rsp1_valid}), 32'(0));
    chk("arst_alu_op_a", 32'(bus_a.o_alu_op_a), 32'(0));
    chk("arst_alu_opcode", 32'(bus_a.o_alu_opcode), 32'(0));
    @(negedge clk);
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 8'h01, 8'h02, 6'h20);
    set_req(1, 1'b1, 8'h03, 8'h04, 6'h20);
    #1 chk("arst_tie_port0", 32'({bus_a.o_req1_ready, bus_a.o_req0_ready}), 32'(2'b01));
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00, 6'h00);
    set_req(1, 1'b0, 8'h00, 8'h00, 6'h00);
    wait_idle("arst_drain");

    // ALU_LAT=3 instance with a slow ALU: 0x5A - 0x33 = 0x27.
    tick();
    bus_b.i_req0_valid = 1'b1; bus_b.i_req0_op_a = 8'h5A;
    bus_b.i_req0_op_b = 8'h33; bus_b.i_req0_opcode = 6'h22;
    #1 chk("lat3_ready0", 32'(bus_b.o_req0_ready), 32'(1));
    tick();
    bus_b.i_req0_valid = 1'b0; bus_b.i_req0_op_a = 8'h00;
    bus_b.i_req0_op_b = 8'h00; bus_b.i_req0_opcode = 6'h00;
    for (int k = 1; k <= LAT_B; k++) begin
      #1;
      chk("lat3_alu_op_a", 32'(bus_b.o_alu_op_a), 32'(8'h5A));
      chk("lat3_alu_opcode", 32'(bus_b.o_alu_opcode), 32'(6'h22));
      chk("lat3_no_rsp", 32'(bus_b.o_rsp0_valid), 32'(0));
      chk("lat3_busy", 32'(busy_b), 32'(1));
      tick();
    end
    #1;
    chk("lat3_rsp_valid", 32'(bus_b.o_rsp0_valid), 32'(1));
    chk("lat3_rsp_data", 32'(bus_b.o_rsp0_data), 32'(8'h27));
    chk("lat3_rsp1_quiet", 32'(bus_b.o_rsp1_valid), 32'(0));
    tick();
    #1;
    chk("lat3_done", 32'({busy_b, bus_b.o_rsp0_valid}), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
